mux_gate_scheduler: RTL and testbench

- Shares one W-bit mux-based logic unit between NUM_REQ requesters.
- The unit evaluates AND/OR/NAND/XOR bitwise as a 2:1 mux: select = a, with i0/i1 chosen per opcode.
- The scheduler arbitrates round-robin, latches operands, sequences evaluation, and returns a tagged result over a valid/ready handshake.
- Sits between client blocks and the shared gate datapath.

---
 rtl/mux_gate_pkg.sv | 31 +++
 rtl/mux_gate_unit.sv | 25 ++
 rtl/mux_gate_scheduler.sv | 130 +++++++++++++
 tb/tb_mux_gate_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_gate_pkg.sv
// Shared types and helpers for the mux-based gate scheduler.
// The optional completion counter is enabled by defining MUX_GATE_SCHED_STATS_EN
// when building the scheduler (see mux_gate_scheduler.sv).
package mux_gate_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_NAND = 2'd2,
    OP_XOR  = 2'd3
  } gate_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // Per-bit mux data inputs for a given opcode; returns {i1, i0}.
  // The operand-a bit selects i1 when high, i0 when low.
  function automatic logic [1:0] gate_mux_sel(gate_op_e op, logic b);
    case (op)
      OP_AND:  return {b, 1'b0};
      OP_OR:   return {1'b1, b};
      OP_NAND: return {~b, 1'b1};
      OP_XOR:  return {~b, b};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mux_gate_unit.sv
// Combinational W-bit logic unit built from per-bit 2:1 muxes (select = a).
module mux_gate_unit
  import mux_gate_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  logic [1:0] sel;

  // One mux per bit; the opcode only decides what feeds the two mux legs.
  always_comb begin
    y_o = '0;
    sel = '0;
    for (int k = 0; k < W; k++) begin
      sel    = gate_mux_sel(gate_op_e'(op_i), b_i[k]);
      y_o[k] = a_i[k] ? sel[1] : sel[0];
    end
  end

endmodule

// File: rtl/mux_gate_scheduler.sv
// Round-robin scheduler sharing one mux_gate_unit between NUM_REQ requesters.
// Accept in IDLE, evaluate for one cycle, then hold the tagged result until
// the consumer takes it. Define MUX_GATE_SCHED_STATS_EN to add done_cnt, a
// saturating count of completed response handshakes.
module mux_gate_scheduler
  import mux_gate_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [W*NUM_REQ-1:0] req_a,
  input  logic [W*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_y,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
`ifdef MUX_GATE_SCHED_STATS_EN
  ,
  output logic [15:0]          done_cnt
`endif
);

  sched_state_e  state_q;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  gate_op_e      op_q;
  logic [W-1:0]  a_q, b_q;
  logic [ID_W-1:0] id_q;
  logic          rsp_valid_q;
  logic [W-1:0]  rsp_y_q;
  logic [ID_W-1:0] rsp_id_q;

  logic          gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic [W-1:0]  unit_y;

  // Search upward from rr_ptr with wrap; first valid requester wins.
  // Grants are suppressed while reset is asserted so nothing looks accepted.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (!rst_n || state_q != IDLE) gnt_found = 1'b0;
    req_ready = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;
    rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  mux_gate_unit #(.W(W)) u_unit (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (unit_y)
  );

  // Scheduler FSM: latch on accept, register the unit output, hold until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            op_q     <= gate_op_e'(req_op[2*gnt_idx +: 2]);
            a_q      <= req_a[W*gnt_idx +: W];
            b_q      <= req_b[W*gnt_idx +: W];
            id_q     <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EVAL;
          end
        end
        EVAL: begin
          rsp_y_q     <= unit_y;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

`ifdef MUX_GATE_SCHED_STATS_EN
  logic [15:0] done_cnt_q;

  // Saturating count of response handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
    end else if (rsp_valid_q && rsp_ready && done_cnt_q != 16'hFFFF) begin
      done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  assign done_cnt = done_cnt_q;
`endif

endmodule

// File: tb/tb_mux_gate_scheduler.sv
// Directed bench for mux_gate_scheduler (NUM_REQ=4, W=8).
module tb_mux_gate_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef MUX_GATE_SCHED_STATS_EN
  logic [15:0] done_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_gate_scheduler #(.NUM_REQ(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef MUX_GATE_SCHED_STATS_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  // Called in IDLE; expects grant to exp_id, then a response with rsp_ready=1.
  task automatic run_txn(input string tag, input int exp_id, input logic chk_y, input logic [7:0] exp_y);
    #1;
    check({tag, "_gnt"}, 32'(req_ready), 32'(4'b0001 << exp_id));
    step();
    check({tag, "_eval_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_eval_busy"}, 32'(busy), 32'(1));
    step();
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1));
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
    if (chk_y) check({tag, "_rsp_y"}, 32'(rsp_y), 32'(exp_y));
    step();
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [7:0] single_exp [4];

  initial begin
    single_exp[0] = 8'h24;
    single_exp[1] = 8'hBD;
    single_exp[2] = 8'hDB;
    single_exp[3] = 8'h99;

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_op    = '0;
    req_a     = 32'h1234_5678;
    req_b     = 32'h9ABC_DEF0;
    rsp_ready = 1'b1;

    // Reset with every requester asking.
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_ready", 32'(req_ready), 32'(0));
      check("rst_valid", 32'(rsp_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_y", 32'(rsp_y), 32'(0));
      check("rst_id", 32'(rsp_id), 32'(0));
    end
    rst_n     = 1'b1;
    req_valid = 4'b0000;

    // Requester 2, all four opcodes.
    for (int op = 0; op < 4; op++) begin
      set_slot(2, 2'(op), 8'hA5, 8'h3C);
      req_valid = 4'b0100;
      #1;
      check("single_gnt", 32'(req_ready), 32'(4'b0100));
      step();
      req_valid = 4'b0000;
      check("single_eval_valid", 32'(rsp_valid), 32'(0));
      step();
      check("single_valid", 32'(rsp_valid), 32'(1));
      check("single_y", 32'(rsp_y), 32'(single_exp[op]));
      check("single_id", 32'(rsp_id), 32'(2));
      step();
      check("single_done", 32'(rsp_valid), 32'(0));
      check("single_idle_busy", 32'(busy), 32'(0));
    end

    // Round-robin from a fresh pointer.
    do_reset();
    req_valid = 4'b1111;
    run_txn("rr0", 0, 1'b0, 8'h00);
    run_txn("rr1", 1, 1'b0, 8'h00);
    run_txn("rr2", 2, 1'b0, 8'h00);
    run_txn("rr3", 3, 1'b0, 8'h00);
    run_txn("rr4", 0, 1'b0, 8'h00);
    req_valid = 4'b1001;
    run_txn("rr_skip3", 3, 1'b0, 8'h00);
    run_txn("rr_wrap0", 0, 1'b0, 8'h00);

    // Backpressure on requester 1: XOR F0 ^ FF = 0F.
    set_slot(1, 2'd3, 8'hF0, 8'hFF);
    req_valid = 4'b0010;
    #1;
    check("bp_gnt", 32'(req_ready), 32'(4'b0010));
    step();
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'(1));
      check("bp_y", 32'(rsp_y), 32'(8'h0F));
      check("bp_id", 32'(rsp_id), 32'(1));
      check("bp_ready", 32'(req_ready), 32'(0));
      check("bp_busy", 32'(busy), 32'(1));
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_last_valid", 32'(rsp_valid), 32'(1));
    step();
    check("bp_done_valid", 32'(rsp_valid), 32'(0));
    check("bp_done_busy", 32'(busy), 32'(0));
    check("bp_next_gnt", 32'(req_ready), 32'(4'b0100));

    // Reset while a response is pending.
    step();
    step();
    check("mid_pre_valid", 32'(rsp_valid), 32'(1));
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", 32'(rsp_valid), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_ready", 32'(req_ready), 32'(0));
    rst_n     = 1'b1;
    req_valid = 4'b1100;
    set_slot(2, 2'd0, 8'hFF, 8'h5A);
    run_txn("mid_regrant", 2, 1'b1, 8'h5A);
    req_valid = 4'b0000;

`ifdef MUX_GATE_SCHED_STATS_EN
    do_reset();
    check("stats_rst", 32'(done_cnt), 32'(0));
    req_valid = 4'b0001;
    run_txn("stats_t0", 0, 1'b0, 8'h00);
    run_txn("stats_t1", 0, 1'b0, 8'h00);
    run_txn("stats_t2", 0, 1'b0, 8'h00);
    req_valid = 4'b0000;
    step();
    step();
    check("stats_cnt3", 32'(done_cnt), 32'(3));
    force dut.done_cnt_q = 16'hFFFF;
    step();
    release dut.done_cnt_q;
    req_valid = 4'b0001;
    run_txn("stats_sat", 0, 1'b0, 8'h00);
    req_valid = 4'b0000;
    check("stats_sat_cnt", 32'(done_cnt), 32'(16'hFFFF));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
